stream_fifo_param: RTL and testbench
====================================

STREAM_FIFO_PARAM -- requirements
Module: stream_fifo_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (1..32).
REQ-002 Parameter DEPTH, default 16, storage entries; power of two, 2..256.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts (1..DEPTH).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ena  input  1  design enable; 0 freezes all transfers.
REQ-007 flush  input  1  synchronous clear of contents, data discarded.
REQ-008 in_data  input  WIDTH  write word.
REQ-009 in_valid  input  1  producer offers in_data.
REQ-010 in_ready  output  1  FIFO accepts a word this cycle.
REQ-011 out_data  output  WIDTH  head word (first-word-fall-through).
REQ-012 out_valid  output  1  out_data holds a valid head word.
REQ-013 out_ready  input  1  consumer takes the head word.
REQ-014 level  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 almost_full  output  1  level >= AF_LEVEL.
REQ-016 empty, full  output  1 each  level==0, level==DEPTH.

Function
REQ-017 Push occurs when in_valid & in_ready at a rising edge; pop when out_valid & out_ready.
REQ-018 in_ready SHALL equal ena & !full & !flush (combinational from state; no full-with-pop pass-through).
REQ-019 out_valid SHALL equal ena & !empty; out_data SHALL equal the oldest stored word, X-free (holds last value or 0) when empty.
REQ-020 Latency: word pushed at edge N SHALL appear on out_valid/out_data immediately after edge N when FIFO was empty.
REQ-021 Simultaneous push and pop (neither full nor empty) SHALL leave level unchanged and preserve order.
REQ-022 Write and read pointers SHALL be clog2(DEPTH) bits and wrap DEPTH-1 -> 0 silently; level tracked as a separate counter.
REQ-023 Push when full or pop when empty SHALL be impossible by construction; in_valid/out_ready ignored then.
REQ-024 flush SHALL have priority over push and pop: next edge level=0, pointers=0, storage contents unchanged but unreachable.
REQ-025 ena=0 SHALL block push, pop and level change; flush and rst still act.
REQ-026 almost_full, empty, full SHALL be registered-state derived, changing only at edges, glitch-free relative to level.
REQ-027 Order SHALL be strict FIFO across any interleaving of pushes, pops and wraps.

Reset
REQ-028 On rst high at an edge: pointers=0, level=0, hence empty=1, full=0, almost_full=0, out_valid=0, in_ready=0 while rst held.
REQ-029 rst SHALL override flush, push and pop; in-flight words are lost; storage array need not be reset.
REQ-030 First push SHALL be accepted on the first edge after rst deasserts with ena=1.

Structure
REQ-031 Package stream_fifo_pkg SHALL hold default WIDTH/DEPTH constants and the level-width helper; no other typedefs.
REQ-032 One sub-module stream_fifo_mem (DEPTH x WIDTH register array, 1 write port, asynchronous read port) SHALL hold storage; control stays in stream_fifo_param.
REQ-033 Parameter legality (power-of-two DEPTH, AF_LEVEL range) SHALL be checked at elaboration.

Verification
REQ-034 DEPTH=4: push 0xA1,0xA2,0xA3,0xA4 with out_ready=0 -> full=1, in_ready=0, level=4, 5th word 0xA5 not accepted.
REQ-035 Then out_ready=1 for 4 cycles -> out_data 0xA1..0xA4 in order, then empty=1, out_valid=0, level=0.
REQ-036 Continuous in_valid/out_ready=1 for 20 cycles, counting data 0..19 -> output 0..19 in order, level stays 1 after first cycle, pointers wrap without loss.
REQ-037 Level 3, AF_LEVEL=3 -> almost_full=1; pop one -> almost_full=0 next edge.
REQ-038 Level 3, assert flush with in_valid=1 and out_ready=1 -> next edge level=0, empty=1, no word accepted or delivered.
REQ-039 Level 2 with ena=0 for 5 cycles, in_valid=out_ready=1 -> level stays 2; rst mid-stream -> level=0, out_valid=0 next edge.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
// stream_fifo_pkg : shared defaults and level-width helper for the stream FIFO
// Rev 1.0
// ============================================================================
package stream_fifo_pkg;

  localparam int C_DEF_WIDTH = 8;
  localparam int C_DEF_DEPTH = 16;

  // Occupancy needs one bit more than the pointers so DEPTH itself is representable.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo_mem.sv
`default_nettype none
// ============================================================================
// stream_fifo_mem : DEPTH x WIDTH register array, one write port, async read
// Rev 1.0
// ============================================================================
module stream_fifo_mem
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH = C_DEF_WIDTH,
  parameter int DEPTH = C_DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/stream_fifo_param.sv
`default_nettype none
// ============================================================================
// stream_fifo_param : first-word-fall-through stream FIFO with level/flags
// Rev 1.0
// ============================================================================
module stream_fifo_param
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH    = C_DEF_WIDTH,
  parameter int DEPTH    = C_DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          almost_full,
  output logic                          empty,
  output logic                          full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);
  localparam logic [LW-1:0] C_FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] C_AF_LVL   = LW'(AF_LEVEL);

  generate
    if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("stream_fifo_param: DEPTH must be a power of two in 2..256");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af_level
      $error("stream_fifo_param: AF_LEVEL must lie in 1..DEPTH");
    end
    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
      $error("stream_fifo_param: WIDTH must lie in 1..32");
    end
  endgenerate

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [LW-1:0]    w_level_nxt;
  logic             r_empty;
  logic             r_full;
  logic             r_af;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;

  // Handshakes are masked during reset so nothing is offered while rst is held.
  assign in_ready    = ena & ~r_full & ~flush & ~rst;
  assign out_valid   = ena & ~r_empty & ~rst;
  assign w_push      = in_valid & in_ready;
  assign w_pop       = out_valid & out_ready;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  // Flags are flopped from the next level so they move in lockstep with it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == C_FULL_LVL);
      r_af    <= (w_level_nxt >= C_AF_LVL);
    end
  end

  stream_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (w_head)
  );

  // Storage is never reset, so present zero rather than stale contents when empty.
  assign out_data    = r_empty ? '0 : w_head;
  assign level       = r_level;
  assign almost_full = r_af;
  assign empty       = r_empty;
  assign full        = r_full;

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo_param.sv
`default_nettype none
// ============================================================================
// tb_stream_fifo_param : directed bench with queue model, DEPTH=4 AF_LEVEL=3
// Rev 1.0
// ============================================================================
module tb_stream_fifo_param;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         flush;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   level;
  logic         almost_full;
  logic         empty;
  logic         full;

  always #5 clk = ~clk;

  stream_fifo_param #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .almost_full (almost_full),
    .empty       (empty),
    .full        (full)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents as a plain queue.
  logic [W-1:0] q[$];
  bit           known = 1'b0;
  bit           m_push;
  bit           m_pop;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      known = 1'b1;
    end else if (flush) begin
      q.delete();
    end else if (ena) begin
      m_push = in_valid && (q.size() < D);
      m_pop  = out_ready && (q.size() > 0);
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(in_data);
    end
  end

  int c_n;
  logic c_ov;

  always @(negedge clk) begin
    if (known) begin
      c_n  = q.size();
      c_ov = ena && !rst && (c_n > 0);
      chk("m_level",     32'(level),       32'(c_n));
      chk("m_empty",     32'(empty),       32'(c_n == 0));
      chk("m_full",      32'(full),        32'(c_n == D));
      chk("m_af",        32'(almost_full), 32'(c_n >= AF));
      chk("m_in_ready",  32'(in_ready),    32'(ena && !rst && !flush && (c_n < D)));
      chk("m_out_valid", 32'(out_valid),   32'(c_ov));
      if (c_ov) chk("m_out_data", 32'(out_data), 32'(q[0]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ena = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    cyc(2);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_level",    32'(level),    32'd0);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_af",       32'(almost_full), 32'd0);
    rst = 1'b0; ena = 1'b1;

    // Fill to full; first word must fall through immediately.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA1 + i);
      cyc(1);
      if (i == 0) begin
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data",  32'(out_data),  32'hA1);
      end
    end
    chk("fill_full",     32'(full),     32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_level",    32'(level),    32'd4);
    in_data = 8'hA5;
    cyc(1);
    chk("ovf_level", 32'(level),    32'd4);
    chk("ovf_head",  32'(out_data), 32'hA1);
    in_valid = 1'b0;

    // Drain in order.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data",  32'(out_data),  32'(8'hA1 + i));
      cyc(1);
    end
    chk("drain_empty", 32'(empty),     32'd1);
    chk("drain_ov",    32'(out_valid), 32'd0);
    chk("drain_level", 32'(level),     32'd0);

    // Streaming with pointer wrap.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(i);
      cyc(1);
      chk("stream_data",  32'(out_data), 32'(i));
      chk("stream_level", 32'(level),    32'd1);
    end
    in_valid = 1'b0;
    cyc(1);
    chk("stream_end_level", 32'(level), 32'd0);

    // almost_full threshold.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'hB0 + i);
      cyc(1);
    end
    in_valid = 1'b0;
    chk("af_level3", 32'(level),       32'd3);
    chk("af_set",    32'(almost_full), 32'd1);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("af_clear", 32'(almost_full), 32'd0);
    chk("af_head",  32'(out_data),    32'hB1);
    in_valid = 1'b1; in_data = 8'hB3;
    cyc(1);
    in_valid = 1'b0;
    chk("pre_flush_level", 32'(level), 32'd3);

    // Flush beats simultaneous push and pop.
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hCC;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    cyc(1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_level", 32'(level),     32'd0);
    chk("flush_empty", 32'(empty),     32'd1);
    chk("flush_ov",    32'(out_valid), 32'd0);

    // Enable freeze, then reset mid-stream.
    in_valid = 1'b1; in_data = 8'hD0;
    cyc(1);
    chk("post_flush_head", 32'(out_data), 32'hD0);
    in_data = 8'hD1;
    cyc(1);
    ena = 1'b0; out_ready = 1'b1; in_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("ena0_level", 32'(level), 32'd2);
    end
    ena = 1'b1;
    cyc(2);
    chk("ena1_level", 32'(level),    32'd2);
    chk("ena1_head",  32'(out_data), 32'hEE);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_level", 32'(level),     32'd0);
    chk("mid_rst_ov",    32'(out_valid), 32'd0);
    rst = 1'b0; in_data = 8'hF0;
    cyc(1);
    chk("post_rst_level", 32'(level),    32'd1);
    chk("post_rst_head",  32'(out_data), 32'hF0);
    in_valid = 1'b0;
    cyc(2);
    chk("final_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
